// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Holds the control state encoding and the elaboration-time log2 helper.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle between a producer stage and the multiplier.
// The slave side is the multiplier; the master side drives operands and accepts products.
interface seq_multiplier_if #(
    parameter int WIDTH = 16
);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   is_signed;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/seq_multiplier_step_unit.sv
// One iteration of the shift-add multiplier: |a| times a BITS_PER_CYCLE-wide digit of |b|.
// Purely combinational; the caller positions the result in the accumulator.
module mul_step_unit #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0]                a_mag,
    input  logic [BITS_PER_CYCLE-1:0]       digit,
    output logic [WIDTH+BITS_PER_CYCLE-1:0] pp
);

    localparam int PP_W = WIDTH + BITS_PER_CYCLE;

    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (digit[i]) begin
                pp = pp + (PP_W'(a_mag) << i);
            end
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned per operation.
// Works on magnitudes and applies the sign once, on the final step.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_multiplier_if.slave       bus
);

    localparam int K      = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W  = (K > 1) ? clog2(K) : 1;
    localparam int SH_W   = clog2(2 * WIDTH) + 1;
    localparam int BPC_LG = clog2(BITS_PER_CYCLE);
    localparam int PP_W   = WIDTH + BITS_PER_CYCLE;
    localparam int P_W    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

    if (!((BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) &&
          (WIDTH % BITS_PER_CYCLE == 0) && (WIDTH >= 2) && (WIDTH % 2 == 0))) begin : g_bad_cfg
        $error("seq_multiplier: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    // |v| for two's-complement input; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        if (sgn && (sv < 0)) begin
            return ~v + WIDTH'(1);
        end
        return v;
    endfunction

    function automatic logic [P_W-1:0] sign_fix(input logic [P_W-1:0] mag, input logic neg);
        return neg ? (~mag + P_W'(1)) : mag;
    endfunction

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_sh;
    logic               neg;
    logic [CNT_W-1:0]   cnt;
    logic [P_W-1:0]     acc;
    logic [P_W-1:0]     acc_nxt;
    logic [P_W-1:0]     product_q;
    logic [PP_W-1:0]    pp;
    logic [SH_W-1:0]    shamt;
    logic               accept;
    logic               step;
    logic               op_neg;

    assign accept = (state == S_IDLE) && bus.in_valid;
    assign step   = (state == S_BUSY);
    assign op_neg = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.in_valid)  state_nxt = S_BUSY;
            S_BUSY:  if (cnt == LAST)   state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            S_IDLE: bus.in_ready = 1'b1;
            S_BUSY: bus.busy     = 1'b1;
            S_DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    mul_step_unit #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .a_mag (a_mag),
        .digit (b_sh[BITS_PER_CYCLE-1:0]),
        .pp    (pp)
    );

    // Digit cnt carries weight 2^(cnt*BITS_PER_CYCLE).
    assign shamt   = SH_W'(cnt) << BPC_LG;
    assign acc_nxt = acc + (P_W'(pp) << shamt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_mag     <= '0;
            b_sh      <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            product_q <= '0;
        end else if (accept) begin
            a_mag <= magnitude(bus.a, bus.is_signed);
            b_sh  <= magnitude(bus.b, bus.is_signed);
            neg   <= op_neg;
            cnt   <= '0;
            acc   <= '0;
        end else if (step) begin
            acc  <= acc_nxt;
            cnt  <= cnt + CNT_W'(1);
            b_sh <= b_sh >> BITS_PER_CYCLE;
            if (cnt == LAST) begin
                product_q <= sign_fix(acc_nxt, neg);
            end
        end
    end

    assign bus.product = product_q;

endmodule
